univ_shift_reg: RTL and testbench

- Parametrised universal shift register; the WIDTH-generic successor to the team's fixed 4-bit serial-in/serial-out shifter.
- Supports hold, shift left/right, parallel load, rotate, arithmetic shift right and clear, all selected by a mode input.
- Counts serial shifts and flags completion of a WIDTH-bit serial frame.
- Used as the common serialiser/deserialiser and bit-manipulation register across lab datapaths.

---
 rtl/univ_shift_reg.sv | 96 +++++++++
 tb/tb_univ_shift_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-generic universal shift register.
// Modes: hold, shift left/right, parallel load, rotate left/right,
// arithmetic shift right, clear. Serial shifts (SHL/SHR) are counted and a
// one-cycle frame_done pulse follows every WIDTH-th serial shift.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sl_in,
    input  logic             sr_in,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             so_msb,
    output logic             so_lsb,
    output logic [CW-1:0]    shift_cnt,
    output logic             frame_done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Counter value reached just before the WIDTH-th serial shift of a frame.
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    shift_cnt_q, shift_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             serial_shift;

    // Next register value selected by mode; en=0 or HOLD keeps contents.
    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], sl_in};
                MODE_SHR:  q_d = {sr_in, q_q[WIDTH-1:1]};
                MODE_LOAD: q_d = pin;
                MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                MODE_CLR:  q_d = '0;
                default:   q_d = q_q;
            endcase
        end
    end

    // Frame counter: only serial shifts advance it, load/clear restart the frame.
    always_comb begin
        shift_cnt_d  = shift_cnt_q;
        frame_done_d = 1'b0;
        serial_shift = en && ((mode == MODE_SHL) || (mode == MODE_SHR));
        if (serial_shift) begin
            if (shift_cnt_q == CNT_LAST) begin
                // Wrap on the same edge as the final shift so frames chain with no gap.
                shift_cnt_d  = '0;
                frame_done_d = 1'b1;
            end else begin
                shift_cnt_d = shift_cnt_q + CNT_ONE;
            end
        end else if (en && ((mode == MODE_LOAD) || (mode == MODE_CLR))) begin
            shift_cnt_d = '0;
        end
    end

    // State registers; reset clears data and aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q          <= '0;
            shift_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            shift_cnt_q  <= shift_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pout       = q_q;
    assign so_msb     = q_q[WIDTH-1];
    assign so_lsb     = q_q[0];
    assign shift_cnt  = shift_cnt_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed and randomized bench for univ_shift_reg (WIDTH=8)
// with a behavioural reference model compared on every falling edge.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W);
    localparam int MASK = (1 << W) - 1;

    localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, LOAD = 3'd3;
    localparam logic [2:0] ROL  = 3'd4, ROR = 3'd5, ASR = 3'd6, CLR  = 3'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [2:0]    mode = HOLD;
    logic          sl_in = 1'b0;
    logic          sr_in = 1'b0;
    logic [W-1:0]  pin = '0;
    logic [W-1:0]  pout;
    logic          so_msb;
    logic          so_lsb;
    logic [CW-1:0] shift_cnt;
    logic          frame_done;

    int errors = 0;
    int checks = 0;

    // Reference model state: register value, serial shifts in current frame, pulse.
    int m_val  = 0;
    int m_cnt  = 0;
    bit m_done = 1'b0;
    bit model_valid = 1'b0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .sl_in      (sl_in),
        .sr_in      (sr_in),
        .pin        (pin),
        .pout       (pout),
        .so_msb     (so_msb),
        .so_lsb     (so_lsb),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the arithmetic meaning of each mode.
    task automatic model_update();
        int sl, sr;
        sl = int'(sl_in);
        sr = int'(sr_in);
        if (rst) begin
            m_val = 0; m_cnt = 0; m_done = 1'b0;
        end else if (!en) begin
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            case (mode)
                SHL:  m_val = (m_val * 2 + sl) % (MASK + 1);
                SHR:  m_val = m_val / 2 + sr * (1 << (W - 1));
                LOAD: m_val = int'(pin);
                ROL:  m_val = (m_val * 2) % (MASK + 1) + m_val / (1 << (W - 1));
                ROR:  m_val = m_val / 2 + (m_val % 2) * (1 << (W - 1));
                ASR:  m_val = m_val / 2 + (m_val / (1 << (W - 1))) * (1 << (W - 1));
                CLR:  m_val = 0;
                default: ;
            endcase
            if (mode == SHL || mode == SHR) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == W) begin
                    m_cnt  = 0;
                    m_done = 1'b1;
                end
            end else if (mode == LOAD || mode == CLR) begin
                m_cnt = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, update model, settle past the edge.
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic sl, input logic sr, input logic [W-1:0] p);
        rst = r; en = e; mode = m; sl_in = sl; sr_in = sr; pin = p;
        @(posedge clk);
        model_update();
        model_valid = 1'b1;
        #1;
    endtask

    // Continuous comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("pout", 32'(pout), 32'(m_val & MASK));
            chk("so_msb", 32'(so_msb), 32'((m_val >> (W - 1)) & 1));
            chk("so_lsb", 32'(so_lsb), 32'(m_val & 1));
            chk("shift_cnt", 32'(shift_cnt), 32'(m_cnt));
            chk("frame_done", 32'(frame_done), 32'(m_done));
        end
    end

    logic [7:0] frame_bits;
    int pulses;

    initial begin
        // Reset dominates an enabled load.
        step(1, 1, LOAD, 0, 0, 8'hFF);
        step(1, 1, LOAD, 0, 0, 8'hFF);
        chk("rst_pout", 32'(pout), 32'h00);
        chk("rst_cnt", 32'(shift_cnt), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);

        // Single operations from 0xA5.
        step(0, 1, LOAD, 0, 0, 8'hA5);
        chk("load_a5", 32'(pout), 32'hA5);
        step(0, 1, SHL, 1, 0, 8'h00);
        chk("shl_a5", 32'(pout), 32'h4B);
        step(0, 1, LOAD, 0, 0, 8'hA5);
        step(0, 1, SHR, 0, 0, 8'h00);
        chk("shr_a5", 32'(pout), 32'h52);
        step(0, 1, LOAD, 0, 0, 8'hA5);
        step(0, 1, ROL, 0, 0, 8'h00);
        chk("rol_a5", 32'(pout), 32'h4B);
        step(0, 1, LOAD, 0, 0, 8'hA5);
        step(0, 1, ROR, 0, 0, 8'h00);
        chk("ror_a5", 32'(pout), 32'hD2);
        step(0, 1, LOAD, 0, 0, 8'h80);
        step(0, 1, ASR, 0, 0, 8'h00);
        chk("asr_80", 32'(pout), 32'hC0);
        step(0, 1, LOAD, 0, 0, 8'hA5);
        step(0, 1, CLR, 0, 0, 8'h00);
        chk("clr_a5", 32'(pout), 32'h00);

        // Full serial frame 1,0,1,1,0,0,1,0 shifted left.
        frame_bits = 8'b1011_0010;
        step(0, 1, LOAD, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, SHL, frame_bits[7 - i], 0, 8'h00);
            if (i == 6) begin
                chk("frame_cnt7", 32'(shift_cnt), 32'd7);
                chk("frame_early_done", 32'(frame_done), 32'd0);
            end
        end
        chk("frame_pout", 32'(pout), 32'hB2);
        chk("frame_cnt", 32'(shift_cnt), 32'd0);
        chk("frame_done", 32'(frame_done), 32'd1);
        chk("frame_msb", 32'(so_msb), 32'd1);
        step(0, 1, HOLD, 0, 0, 8'h00);
        chk("frame_done_1cyc", 32'(frame_done), 32'd0);

        // Gated frame: enable gap must freeze the count.
        step(0, 1, LOAD, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 1, SHL, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, SHL, 0, 0, 8'h00);
            chk("gap_cnt", 32'(shift_cnt), 32'd3);
            chk("gap_done", 32'(frame_done), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, SHL, 0, 0, 8'h00);
            chk("gated_done", 32'(frame_done), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("gated_pout", 32'(pout), 32'hE0);

        // Abort mid-frame with reset.
        for (int i = 0; i < 5; i++) step(0, 1, SHL, 1, 0, 8'h00);
        step(1, 1, SHL, 1, 0, 8'h00);
        step(0, 1, SHL, 1, 0, 8'h00);
        step(0, 1, SHL, 0, 0, 8'h00);
        step(0, 1, SHL, 1, 0, 8'h00);
        chk("abort_pout", 32'(pout), 32'h05);
        chk("abort_cnt", 32'(shift_cnt), 32'd3);
        chk("abort_done", 32'(frame_done), 32'd0);

        // Back-to-back SHR frames with ROR interleaved.
        step(0, 1, LOAD, 0, 0, 8'h3C);
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, SHR, i[0], 0, 8'h00);
            if (frame_done) pulses++;
            chk("b2b_done", 32'(frame_done), (i == 8 || i == 16) ? 32'd1 : 32'd0);
            if (i == 3 || i == 11) begin
                step(0, 1, ROR, 0, 0, 8'h00);
                chk("ror_cnt_hold", 32'(shift_cnt), 32'(i % 8));
                chk("ror_no_done", 32'(frame_done), 32'd0);
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'd2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 8'($urandom));
        end

        @(negedge clk);
        model_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
